// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding, stall-controller state encoding.
package cpu_pkg;

   localparam logic [3:0]  OP_LD     = 4'b1000;
   localparam logic [3:0]  OP_ST     = 4'b1001;
   localparam logic [3:0]  OP_B      = 4'b1100;
   localparam logic [3:0]  OP_BR     = 4'b1101;
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LDUSE  = 2'd1,
      BRWAIT = 2'd2
   } pctl_state_t;

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_B) || (op == OP_BR);
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-unit/EX inputs and per-stage pipeline controls of the stall controller.
interface pipeline_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             stall_req;
   logic [3:0]       id_ex_opcode;
   logic             br_resolve;
   logic             br_taken;
   logic             ext_hold;
   logic             pc_en;
   logic             pc_sel_br;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_bubble;
   logic             ex_mem_bubble;
   logic [CNT_W-1:0] stall_cnt;
   logic             br_err;

   modport master (
      output stall_req, id_ex_opcode, br_resolve, br_taken, ext_hold,
      input  pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en,
             id_ex_bubble, ex_mem_bubble, stall_cnt, br_err
   );

   modport slave (
      input  stall_req, id_ex_opcode, br_resolve, br_taken, ext_hold,
      output pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en,
             id_ex_bubble, ex_mem_bubble, stall_cnt, br_err
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over enable.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns hazard stall requests and branch resolution into per-stage pipeline controls.
//
// state  | meaning
// RUN    | normal flow; detects load-use and branch in ID/EX
// LDUSE  | remaining load-use freeze cycles, cnt counts down
// BRWAIT | branch in EX awaiting resolve, cnt counts wait cycles
module pipeline_stall_ctrl
   import cpu_pkg::*;
#(
   parameter int LD_STALL_CYC = 1,
   parameter int BR_TIMEOUT   = 8,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_stall_ctrl_if.slave ctl
);

   localparam logic [7:0] LD_CNT_INIT = 8'(LD_STALL_CYC - 1);
   localparam logic [7:0] BR_TMO_LAST = 8'(BR_TIMEOUT - 1);

   pctl_state_t state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        br_err_q, br_err_d;

   logic pc_en_c, pc_sel_br_c, if_id_en_c, if_id_flush_c;
   logic id_ex_en_c, id_ex_bubble_c, ex_mem_bubble_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         cnt_q    <= '0;
         br_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         br_err_q <= br_err_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      br_err_d        = br_err_q;
      pc_en_c         = 1'b1;
      pc_sel_br_c     = 1'b0;
      if_id_en_c      = 1'b1;
      if_id_flush_c   = 1'b0;
      id_ex_en_c      = 1'b1;
      id_ex_bubble_c  = 1'b0;
      ex_mem_bubble_c = 1'b0;

      // Hold freezes everything, so a resolve seen here is dropped and must be re-presented.
      if (ctl.ext_hold) begin
         pc_en_c    = 1'b0;
         if_id_en_c = 1'b0;
         id_ex_en_c = 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (is_branch(ctl.id_ex_opcode)) begin
                  pc_en_c        = 1'b0;
                  if_id_en_c     = 1'b0;
                  id_ex_bubble_c = 1'b1;
                  state_d        = BRWAIT;
                  cnt_d          = '0;
               end else if (ctl.stall_req) begin
                  pc_en_c         = 1'b0;
                  if_id_en_c      = 1'b0;
                  id_ex_en_c      = 1'b0;
                  ex_mem_bubble_c = 1'b1;
                  if (LD_STALL_CYC > 1) begin
                     state_d = LDUSE;
                     cnt_d   = LD_CNT_INIT;
                  end
               end
            end
            LDUSE: begin
               pc_en_c         = 1'b0;
               if_id_en_c      = 1'b0;
               id_ex_en_c      = 1'b0;
               ex_mem_bubble_c = 1'b1;
               cnt_d           = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = RUN;
               end
            end
            BRWAIT: begin
               pc_en_c        = 1'b0;
               if_id_en_c     = 1'b0;
               id_ex_bubble_c = 1'b1;
               if (ctl.br_resolve) begin
                  pc_en_c    = 1'b1;
                  if_id_en_c = 1'b1;
                  state_d    = RUN;
                  if (ctl.br_taken) begin
                     pc_sel_br_c   = 1'b1;
                     if_id_flush_c = 1'b1;
                  end else begin
                     id_ex_bubble_c = 1'b0;
                  end
               end else if (cnt_q == BR_TMO_LAST) begin
                  br_err_d = 1'b1;
                  state_d  = RUN;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (!pc_en_c && !ctl.ext_hold),
      .cnt_o (ctl.stall_cnt)
   );

   assign ctl.pc_en         = pc_en_c;
   assign ctl.pc_sel_br     = pc_sel_br_c;
   assign ctl.if_id_en      = if_id_en_c;
   assign ctl.if_id_flush   = if_id_flush_c;
   assign ctl.id_ex_en      = id_ex_en_c;
   assign ctl.id_ex_bubble  = id_ex_bubble_c;
   assign ctl.ex_mem_bubble = ex_mem_bubble_c;
   assign ctl.br_err        = br_err_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed vector bench: dut_a (3-cycle load-use, 16-bit count), dut_b (1-cycle load-use, 2-bit count).
module tb_pipeline_stall_ctrl;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       stall_req, br_resolve, br_taken, ext_hold;
   logic [3:0] opcode;

   always #5 clk = ~clk;

   pipeline_stall_ctrl_if #(.CNT_W(16)) ifa ();
   pipeline_stall_ctrl_if #(.CNT_W(2))  ifb ();

   assign ifa.stall_req    = stall_req;
   assign ifa.id_ex_opcode = opcode;
   assign ifa.br_resolve   = br_resolve;
   assign ifa.br_taken     = br_taken;
   assign ifa.ext_hold     = ext_hold;
   assign ifb.stall_req    = stall_req;
   assign ifb.id_ex_opcode = opcode;
   assign ifb.br_resolve   = br_resolve;
   assign ifb.br_taken     = br_taken;
   assign ifb.ext_hold     = ext_hold;

   pipeline_stall_ctrl #(.LD_STALL_CYC(3), .BR_TIMEOUT(8), .CNT_W(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .ctl (ifa)
   );

   pipeline_stall_ctrl #(.LD_STALL_CYC(1), .BR_TIMEOUT(8), .CNT_W(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .ctl (ifb)
   );

   // {pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble}
   localparam logic [6:0] C_RUN = 7'b1010100;
   localparam logic [6:0] C_LD  = 7'b0000001;
   localparam logic [6:0] C_BR  = 7'b0000110;
   localparam logic [6:0] C_TK  = 7'b1111110;
   localparam logic [6:0] C_NT  = 7'b1010100;
   localparam logic [6:0] C_HLD = 7'b0000000;

   logic [6:0] ctrl_a, ctrl_b;
   assign ctrl_a = {ifa.pc_en, ifa.pc_sel_br, ifa.if_id_en, ifa.if_id_flush,
                    ifa.id_ex_en, ifa.id_ex_bubble, ifa.ex_mem_bubble};
   assign ctrl_b = {ifb.pc_en, ifb.pc_sel_br, ifb.if_id_en, ifb.if_id_flush,
                    ifb.id_ex_en, ifb.id_ex_bubble, ifb.ex_mem_bubble};

   typedef struct {
      logic        rst;
      logic        sreq;
      logic [3:0]  op;
      logic        res;
      logic        tk;
      logic        hold;
      logic [6:0]  ctrl;
      pctl_state_t st;
      logic [7:0]  cnt;
      logic [15:0] sc;
      logic        err;
   } vec_t;

   vec_t vq[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   task automatic add(input logic r, input logic s, input logic [3:0] op, input logic res,
                      input logic tk, input logic h, input logic [6:0] c, input pctl_state_t st,
                      input logic [7:0] cnt, input logic [15:0] sc, input logic err);
      vec_t v;
      v.rst = r; v.sreq = s; v.op = op; v.res = res; v.tk = tk; v.hold = h;
      v.ctrl = c; v.st = st; v.cnt = cnt; v.sc = sc; v.err = err;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic r, input logic s, input logic [3:0] op, input logic res,
                        input logic tk, input logic h);
      rst = r; stall_req = s; opcode = op; br_resolve = res; br_taken = tk; ext_hold = h;
   endtask

   task automatic step_b(input int idx, input logic s, input logic [6:0] ec, input logic [1:0] esc);
      @(negedge clk);
      drive(1'b0, s, 4'b0000, 1'b0, 1'b0, 1'b0);
      #2;
      chk("b_ctrl", idx, 32'(ctrl_b), 32'(ec));
      chk("b_stall_cnt", idx, 32'(ifb.stall_cnt), 32'(esc));
      chk("b_state", idx, 32'(dut_b.state_q), 32'(RUN));
   endtask

   initial begin
      drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      //   rst  sreq op       res  tk   hold ctrl   state   cnt sc  err
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    0, 0,  0); // 0 reset state
      add(0, 1, 4'b0000, 0, 0, 0, C_LD,  RUN,    0, 0,  0); // 1 load-use x3
      add(0, 0, 4'b0000, 0, 0, 0, C_LD,  LDUSE,  2, 1,  0);
      add(0, 0, 4'b0000, 0, 0, 0, C_LD,  LDUSE,  1, 2,  0);
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    0, 3,  0);
      add(0, 0, 4'b1100, 0, 0, 0, C_BR,  RUN,    0, 3,  0); // 5 taken B
      add(0, 0, 4'b0000, 0, 0, 0, C_BR,  BRWAIT, 0, 4,  0);
      add(0, 0, 4'b0000, 1, 1, 0, C_TK,  BRWAIT, 1, 5,  0);
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    1, 5,  0);
      add(0, 0, 4'b1101, 0, 0, 0, C_BR,  RUN,    1, 5,  0); // 9 not-taken BR
      add(0, 0, 4'b0000, 0, 0, 0, C_BR,  BRWAIT, 0, 6,  0);
      add(0, 0, 4'b0000, 1, 0, 0, C_NT,  BRWAIT, 1, 7,  0);
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    1, 7,  0);
      add(0, 0, 4'b0000, 1, 1, 0, C_RUN, RUN,    1, 7,  0); // 13 resolve in RUN
      add(0, 1, 4'b1101, 0, 0, 0, C_BR,  RUN,    1, 7,  0); // 14 branch beats stall_req
      add(0, 0, 4'b0000, 0, 0, 0, C_BR,  BRWAIT, 0, 8,  0);
      add(0, 0, 4'b0000, 0, 0, 1, C_HLD, BRWAIT, 1, 9,  0); // 16 hold in BRWAIT
      add(0, 0, 4'b0000, 1, 1, 1, C_HLD, BRWAIT, 1, 9,  0);
      add(0, 0, 4'b0000, 0, 0, 1, C_HLD, BRWAIT, 1, 9,  0);
      add(0, 0, 4'b0000, 0, 0, 1, C_HLD, BRWAIT, 1, 9,  0);
      add(1, 0, 4'b0000, 0, 0, 0, C_BR,  BRWAIT, 1, 9,  0); // 20 rst mid-BRWAIT
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    0, 0,  0);
      add(0, 1, 4'b0000, 0, 0, 1, C_HLD, RUN,    0, 0,  0); // 22 hold beats load-use
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    0, 0,  0);
      add(0, 0, 4'b1100, 0, 0, 0, C_BR,  RUN,    0, 0,  0); // 24 timeout
      for (int k = 0; k < 8; k++)
         add(0, 0, 4'b0000, 0, 0, 0, C_BR, BRWAIT, 8'(k), 16'(k + 1), 0);
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    7, 9,  1); // 33 sticky err
      add(0, 1, 4'b0000, 0, 0, 0, C_LD,  RUN,    7, 9,  1);
      add(0, 0, 4'b0000, 1, 1, 0, C_LD,  LDUSE,  2, 10, 1); // 35 resolve in LDUSE
      add(0, 0, 4'b0000, 0, 0, 0, C_LD,  LDUSE,  1, 11, 1);
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    0, 12, 1);
      add(1, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    0, 12, 1); // 38 rst clears err
      add(0, 0, 4'b0000, 0, 0, 0, C_RUN, RUN,    0, 0,  0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].rst, vq[i].sreq, vq[i].op, vq[i].res, vq[i].tk, vq[i].hold);
         #2;
         chk("ctrl", i, 32'(ctrl_a), 32'(vq[i].ctrl));
         chk("state", i, 32'(dut_a.state_q), 32'(vq[i].st));
         chk("cnt", i, 32'(dut_a.cnt_q), 32'(vq[i].cnt));
         chk("stall_cnt", i, 32'(ifa.stall_cnt), 32'(vq[i].sc));
         chk("br_err", i, 32'(ifa.br_err), 32'(vq[i].err));
      end

      // Single-cycle load-use stays in RUN; 2-bit stall_cnt saturates at 3.
      step_b(100, 1'b1, C_LD,  2'd0);
      step_b(101, 1'b0, C_RUN, 2'd1);
      step_b(102, 1'b1, C_LD,  2'd1);
      step_b(103, 1'b1, C_LD,  2'd2);
      step_b(104, 1'b1, C_LD,  2'd3);
      step_b(105, 1'b0, C_RUN, 2'd3);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the hazard unit's stall request and turns it into per-stage pipeline controls for the 4-bit-opcode 5-stage CPU.
- Controls are the PC enable, IF/ID and ID/EX enables, bubble injection, branch redirect and IF/ID flush.
- Sequences multi-cycle load-use stalls and branch-resolution waits.
- Keeps a saturating stall-cycle counter and a sticky branch-timeout error.

Parameters:
- LD_STALL_CYC, 1, total freeze cycles per load-use hazard (1..15).
- BR_TIMEOUT, 8, max BRWAIT cycles without br_resolve before abort (2..255).
- CNT_W, 16, stall_cnt width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- stall_req  in  1  hazard-unit stall (load-use or B/BR in ID/EX).
- id_ex_opcode  in  4  opcode held in ID/EX.
- br_resolve  in  1  EX reports branch outcome this cycle.
- br_taken  in  1  outcome, valid only with br_resolve.
- ext_hold  in  1  memory/external freeze of the whole pipe.
- pc_en  out  1  PC register load enable.
- pc_sel_br  out  1  PC mux selects branch target.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_bubble  out  1  ID/EX loads NOP.
- ex_mem_bubble  out  1  EX/MEM loads NOP.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 and ext_hold=0.
- br_err  out  1  sticky; branch timeout occurred.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state RUN, counter 0, stall_cnt 0, br_err 0.
- Output defaults: control outputs are combinational from state, counter and inputs. In RUN with idle inputs: pc_en=1, if_id_en=1, id_ex_en=1; all bubbles, flush and pc_sel_br are 0.
- States: RUN, LDUSE, BRWAIT. The state register and 8-bit cnt are the only sequential state besides stall_cnt and br_err.
- Branch opcodes: B=4'b1100, BR=4'b1101. is_br = (id_ex_opcode is B or BR).

RUN:
- stall_req & !is_br (load-use), same cycle:
  - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_bubble=1.
  - If LD_STALL_CYC>1: next LDUSE, cnt=LD_STALL_CYC-1. Otherwise stay in RUN.
- is_br (stall_req ignored), same cycle:
  - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1. The branch advances to EX and a NOP follows it.
  - Next BRWAIT, cnt=0.

LDUSE:
- Same freeze as the RUN load-use cycle.
- cnt decrements each cycle; at cnt==1, next RUN.

BRWAIT:
- Default outputs: pc_en=0, if_id_en=0, id_ex_bubble=1.
- br_resolve & br_taken: pc_sel_br=1, pc_en=1, if_id_flush=1, if_id_en=1; next RUN.
- br_resolve & !br_taken: pc_en=1, if_id_en=1, id_ex_bubble=0; next RUN.
- No resolve: cnt++. When cnt==BR_TIMEOUT-1 without resolve, set br_err and go to RUN with not-taken outputs on the next cycle.

Priority and boundaries:
- ext_hold has highest priority after rst. All enables are 0; bubbles, flush and pc_sel_br are 0. State, cnt and stall_cnt are frozen. A br_resolve pulse under ext_hold is ignored; the EX stage must re-present it.
- br_resolve in RUN or LDUSE is ignored.
- rst mid-LDUSE or mid-BRWAIT returns to RUN next edge with the reset values.
- stall_cnt saturates at all-ones; it does not wrap.
- br_err is cleared only by rst.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_LD=4'b1000, OP_ST=4'b1001, OP_B=4'b1100, OP_BR=4'b1101.
  - state enum pctl_state_t {RUN, LDUSE, BRWAIT}.
  - NOP instruction constant.
- Sub-module sat_counter (parameterised width, enable, sync clear) implements stall_cnt.
- FSM and output decode stay in pipeline_stall_ctrl.

Test Plan:
- Load-use, LD_STALL_CYC=1: stall_req=1 and opcode 0000 for one cycle -> that cycle pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_bubble=1; next cycle all defaults; stall_cnt=1.
- Load-use, LD_STALL_CYC=3: stall_req pulse -> freeze outputs for exactly 3 cycles, state RUN→LDUSE→LDUSE→RUN; stall_cnt=3.
- Taken branch: opcode 1100 in RUN, br_resolve=1 and br_taken=1 two cycles later -> detection cycle id_ex_bubble=1 and pc_en=0; one BRWAIT cycle with pc_en=0; resolve cycle pc_sel_br=1, pc_en=1, if_id_flush=1; then RUN; stall_cnt=2.
- Not-taken BR (1101) resolved after 1 BRWAIT cycle -> resolve cycle pc_en=1, pc_sel_br=0, if_id_flush=0; next cycle RUN defaults.
- Timeout, BR_TIMEOUT=8: branch enters BRWAIT with no resolve -> 8 BRWAIT cycles, then br_err=1 and state RUN; br_err stays 1 until rst.
- ext_hold=1 for 4 cycles in BRWAIT, with a br_resolve pulse during the hold -> all enables 0 during the hold; cnt and stall_cnt unchanged; pulse ignored; state still BRWAIT after the hold. Then assert rst mid-BRWAIT -> RUN defaults and stall_cnt=0 next cycle.
